// File: rtl/sdram_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : sdram_frame_sched
// Purpose  : SDRAM burst request scheduler for a ping-pong frame buffer.
//            Issues one line-sized write or read burst at a time, arbitrates
//            write vs. read round-robin, and steers the writer and the
//            display reader onto opposite buffers so a frame under
//            construction is never shown.
// Options  : define SCHED_STATS_EN to add frame/stall statistic counters.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_frame_sched #(
    parameter int ADDR_W    = 24,
    parameter int ROW_LSB   = 9,
    parameter int LINE_W    = 13,
    parameter int LINES     = 128,
    parameter int BUF_BIT   = 22,
    parameter int FIFO_W    = 11,
    parameter int WR_THRESH = 512,
    parameter int RD_THRESH = 512
) (
    input  logic              clk_133M_i,
    input  logic              rst_133i,
    input  logic [FIFO_W-1:0] wr_fifo_used_i,
    input  logic [FIFO_W-1:0] rd_fifo_used_i,
    input  logic              vsync_i,
    output logic              wr_req_o,
    input  logic              wr_ack_i,
    output logic [ADDR_W-1:0] wr_add_o,
    output logic              rd_req_o,
    input  logic              rd_ack_i,
    output logic [ADDR_W-1:0] rd_add_o,
    output logic              wr_buf_o,
    output logic              rd_buf_o,
    output logic              frame_ready_o,
    output logic              wr_frame_done_o,
    output logic              wr_stall_o
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]       frames_wr_o,
    output logic [15:0]       frames_rd_o,
    output logic [23:0]       stall_cyc_o
`endif
);

    // Line counters are one bit wider than the field so they can hold LINES.
    localparam logic [LINE_W:0]   LINES_C   = (LINE_W+1)'(LINES);
    localparam logic [LINE_W:0]   LAST_LINE = (LINE_W+1)'(LINES - 1);
    localparam logic [LINE_W:0]   LINE_ONE  = (LINE_W+1)'(1);
    localparam logic [FIFO_W-1:0] WR_TH     = FIFO_W'(WR_THRESH);
    localparam logic [FIFO_W-1:0] RD_TH     = FIFO_W'(RD_THRESH);

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WR_BUSY = 2'd1,
        ARB_RD_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        WR_ACTIVE   = 1'b0,
        WR_WAIT_BUF = 1'b1
    } wr_state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    arb_state_t      arb_state;
    wr_state_t       wr_state;
    grant_t          last_grant;
    logic [LINE_W:0] wr_line;
    logic [LINE_W:0] rd_line;
    logic            last_done;

    logic              wr_elig;
    logic              rd_elig;
    logic              wr_done_evt;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [ADDR_W-1:0] rd_addr_next;

    // Build a burst address: buffer select bit plus line index, all else zero.
    function automatic logic [ADDR_W-1:0] mk_addr(input logic buf_sel,
                                                  input logic [LINE_W:0] line);
        logic [ADDR_W-1:0] a;
        a                      = '0;
        a[BUF_BIT]             = buf_sel;
        a[ROW_LSB +: LINE_W]   = line[LINE_W-1:0];
        return a;
    endfunction

    // Eligibility of each side, next burst addresses, and frame-end detect.
    always_comb begin
        wr_elig      = (wr_state == WR_ACTIVE) && (wr_fifo_used_i >= WR_TH) &&
                       (wr_line < LINES_C);
        rd_elig      = frame_ready_o && vsync_i && (rd_line < LINES_C) &&
                       (rd_fifo_used_i <= RD_TH);
        wr_done_evt  = (arb_state == ARB_WR_BUSY) && wr_ack_i && (wr_line == LAST_LINE);
        wr_addr_next = mk_addr(wr_buf_o, wr_line);
        rd_addr_next = mk_addr(rd_buf_o, rd_line);
    end

    // Arbiter, writer buffer FSM and reader frame control.
    always_ff @(posedge clk_133M_i) begin
        if (rst_133i) begin
            arb_state       <= ARB_IDLE;
            wr_state        <= WR_ACTIVE;
            last_grant      <= GRANT_RD;
            wr_line         <= '0;
            rd_line         <= '0;
            last_done       <= 1'b0;
            wr_req_o        <= 1'b0;
            rd_req_o        <= 1'b0;
            wr_add_o        <= '0;
            rd_add_o        <= '0;
            wr_buf_o        <= 1'b0;
            rd_buf_o        <= 1'b0;
            frame_ready_o   <= 1'b0;
            wr_frame_done_o <= 1'b0;
            wr_stall_o      <= 1'b0;
        end else begin
            wr_frame_done_o <= 1'b0;

            // Addresses are frozen while their request is outstanding.
            if (!wr_req_o) wr_add_o <= wr_addr_next;
            if (!rd_req_o) rd_add_o <= rd_addr_next;

            case (arb_state)
                ARB_IDLE: begin
                    if (wr_elig && (!rd_elig || (last_grant == GRANT_RD))) begin
                        arb_state  <= ARB_WR_BUSY;
                        wr_req_o   <= 1'b1;
                        last_grant <= GRANT_WR;
                    end else if (rd_elig) begin
                        arb_state  <= ARB_RD_BUSY;
                        rd_req_o   <= 1'b1;
                        last_grant <= GRANT_RD;
                    end
                end
                ARB_WR_BUSY: begin
                    if (wr_ack_i) begin
                        wr_req_o  <= 1'b0;
                        arb_state <= ARB_IDLE;
                        if (wr_done_evt) begin
                            wr_frame_done_o <= 1'b1;
                            last_done       <= wr_buf_o;
                            frame_ready_o   <= 1'b1;
                            wr_line         <= '0;
                            // Other buffer is free unless the reader sits on it.
                            if (rd_buf_o != ~wr_buf_o) begin
                                wr_buf_o <= ~wr_buf_o;
                            end else begin
                                wr_state   <= WR_WAIT_BUF;
                                wr_stall_o <= 1'b1;
                            end
                        end else begin
                            wr_line <= wr_line + LINE_ONE;
                        end
                    end
                end
                ARB_RD_BUSY: begin
                    if (rd_ack_i) begin
                        rd_req_o  <= 1'b0;
                        arb_state <= ARB_IDLE;
                        // A read finishing during blank restarts the frame.
                        rd_line   <= vsync_i ? (rd_line + LINE_ONE) : '0;
                    end
                end
                default: begin
                    arb_state <= ARB_IDLE;
                    wr_req_o  <= 1'b0;
                    rd_req_o  <= 1'b0;
                end
            endcase

            // Writer leaves the stall once the reader has moved to the last frame.
            if ((wr_state == WR_WAIT_BUF) && (rd_buf_o == last_done)) begin
                wr_buf_o   <= ~last_done;
                wr_state   <= WR_ACTIVE;
                wr_stall_o <= 1'b0;
            end

            // During vertical blank the reader jumps to the newest complete frame.
            if (!vsync_i) begin
                if (frame_ready_o) rd_buf_o <= last_done;
                if (arb_state != ARB_RD_BUSY) rd_line <= '0;
            end
        end
    end

`ifdef SCHED_STATS_EN
    logic rd_done_evt;

    // A read completes a frame only if it lands outside blank on the last line.
    always_comb begin
        rd_done_evt = (arb_state == ARB_RD_BUSY) && rd_ack_i && vsync_i &&
                      (rd_line == LAST_LINE);
    end

    // Free-running wrap-around statistics.
    always_ff @(posedge clk_133M_i) begin
        if (rst_133i) begin
            frames_wr_o <= '0;
            frames_rd_o <= '0;
            stall_cyc_o <= '0;
        end else begin
            if (wr_done_evt) frames_wr_o <= frames_wr_o + 16'd1;
            if (rd_done_evt) frames_rd_o <= frames_rd_o + 16'd1;
            if (wr_stall_o)  stall_cyc_o <= stall_cyc_o + 24'd1;
        end
    end
`endif

endmodule
`default_nettype wire
